// File: rtl/lfsr_checker.sv
// PRBS receiver for the Fibonacci LFSR word stream: hunts for lock, then free-runs
// a local LFSR copy and counts bit errors and checked words with saturating counters.
module lfsr_checker #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(15'h6000),
  parameter int                    LFSR_LEN   = 15,
  parameter int                    LOCK_CNT   = 16,
  parameter int                    LOSS_CNT   = 4,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);

  localparam int PW = $clog2(DATA_WIDTH + 1);
  // Sum width covers both the counter and a full-word popcount so neither wraps.
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [DATA_WIDTH-1:0] LEN_MASK =
    (LFSR_LEN >= DATA_WIDTH) ? '1 : ((DATA_WIDTH'(1) << LFSR_LEN) - DATA_WIDTH'(1));
  localparam logic [DATA_WIDTH-1:0] TAPS    = LFSR_POLY & LEN_MASK;
  localparam logic [SW-1:0]         CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-2:0], ^(x & TAPS)};
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [DATA_WIDTH-1:0] x);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) n = n + PW'(x[i]);
    return n;
  endfunction

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic                    have_prev_q, have_prev_d;
  logic [7:0]              match_q, match_d;
  logic [7:0]              miss_q, miss_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    bit_err_q, bit_err_d;
  logic [CNT_WIDTH-1:0]    word_q, word_d;
  logic                    word_hit;
  logic [DATA_WIDTH-1:0]   err_bits;
  logic [SW-1:0]           bit_sum;
  logic [CNT_WIDTH:0]      word_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
      bit_err_q   <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      bit_err_q   <= bit_err_d;
      word_q      <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    word_hit    = 1'b0;
    err_bits    = '0;
    if (valid_i) begin
      case (state_q)
        HUNT: begin
          exp_d       = nxt(data_i);
          have_prev_d = 1'b1;
          // The all-zero lockup word never counts toward lock.
          if (have_prev_q && (data_i == exp_q) && (data_i != '0)) begin
            match_d = match_q + 8'd1;
            if (match_d == 8'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          exp_d    = nxt(exp_q);
          word_hit = 1'b1;
          err_bits = data_i ^ exp_q;
          if (err_bits != '0) begin
            err_d  = 1'b1;
            miss_d = miss_q + 8'd1;
            if (miss_d == 8'(LOSS_CNT)) begin
              state_d     = HUNT;
              match_d     = '0;
              exp_d       = nxt(data_i);
              have_prev_d = 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    bit_sum   = SW'(bit_err_q) + SW'(popcount(err_bits));
    word_sum  = {1'b0, word_q} + (CNT_WIDTH + 1)'(1);
    bit_err_d = bit_err_q;
    word_d    = word_q;
    if (clr_i) begin
      bit_err_d = '0;
      word_d    = '0;
    end else if (word_hit) begin
      word_d    = word_sum[CNT_WIDTH] ? '1 : word_sum[CNT_WIDTH-1:0];
      bit_err_d = (bit_sum > CNT_MAX) ? '1 : bit_sum[CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    locked_o      = (state_q == LOCKED);
    err_o         = err_q;
    bit_err_cnt_o = bit_err_q;
    word_cnt_o    = word_q;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, error counting, loss/re-lock, gaps,
// zero stream, counter clear/saturation (4-bit counter instance) and reset mid-lock.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        clr_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        locked_o, err_o;
  logic [31:0] bit_err_cnt_o, word_cnt_o;
  logic        s_locked_o, s_err_o;
  logic [3:0]  s_bit_err_cnt_o, s_word_cnt_o;

  int          n_vec;
  int          n_err;
  logic [31:0] gen;

  lfsr_checker dut (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .locked_o      (locked_o),
    .err_o         (err_o),
    .bit_err_cnt_o (bit_err_cnt_o),
    .word_cnt_o    (word_cnt_o)
  );

  // Narrow counters and a long loss window so saturation is reached while locked.
  lfsr_checker #(.CNT_WIDTH(4), .LOSS_CNT(16)) dut_s (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .locked_o      (s_locked_o),
    .err_o         (s_err_o),
    .bit_err_cnt_o (s_bit_err_cnt_o),
    .word_cnt_o    (s_word_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generator: taps at bits 14 and 13 (poly 15'h6000), one bit shifted in per word.
  function automatic logic [31:0] gen_nxt(input logic [31:0] x);
    return {x[30:0], x[14] ^ x[13]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic v);
    data_i  = d;
    valid_i = v;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  task automatic send_clean();
    send(gen, 1'b1);
    gen = gen_nxt(gen);
  endtask

  task automatic send_bad(input logic [31:0] mask);
    send(gen ^ mask, 1'b1);
    gen = gen_nxt(gen);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gen = 32'h1;
  endtask

  initial begin
    int pulses;
    logic saw;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    gen     = 32'h1;

    do_reset();
    check("reset_locked", 32'(locked_o), 0);
    check("reset_err", 32'(err_o), 0);
    check("reset_bit_cnt", bit_err_cnt_o, 0);
    check("reset_word_cnt", word_cnt_o, 0);

    // 1. Clean lock
    for (int i = 1; i <= 17; i++) begin
      send_clean();
      if (i == 16) check("lock_not_before_17", 32'(locked_o), 0);
    end
    check("lock_after_17", 32'(locked_o), 1);
    check("lock_word_not_counted", word_cnt_o, 0);
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      send_clean();
      saw = saw | err_o;
    end
    check("clean_word_cnt", word_cnt_o, 100);
    check("clean_bit_cnt", bit_err_cnt_o, 0);
    check("clean_no_err", 32'(saw), 0);

    // 2. Single-bit and full-word errors
    send_bad(32'h1);
    check("bit0_err", 32'(err_o), 1);
    check("bit0_cnt", bit_err_cnt_o, 1);
    check("bit0_locked", 32'(locked_o), 1);
    send_clean();
    check("after_bit0_err", 32'(err_o), 0);
    check("after_bit0_cnt", bit_err_cnt_o, 1);
    send_bad(32'hFFFF_FFFF);
    check("allbits_err", 32'(err_o), 1);
    check("allbits_cnt", bit_err_cnt_o, 33);
    send_clean();
    check("after_allbits_err", 32'(err_o), 0);
    check("word_cnt_104", word_cnt_o, 104);

    // 3. Three bad words keep lock; four drop it
    for (int i = 0; i < 3; i++) send_bad(32'h1);
    check("three_bad_locked", 32'(locked_o), 1);
    send_clean();
    check("three_bad_recover_err", 32'(err_o), 0);
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      send_bad(32'h1);
      if (err_o) pulses++;
      if (i == 3) check("bad3_still_locked", 32'(locked_o), 1);
    end
    check("bad4_unlocked", 32'(locked_o), 0);
    check("bad4_err_pulses", 32'(pulses), 4);
    check("loss_word_cnt", word_cnt_o, 112);
    check("loss_bit_cnt", bit_err_cnt_o, 40);
    for (int i = 1; i <= 17; i++) begin
      send_clean();
      if (i == 16) check("relock_not_before_17", 32'(locked_o), 0);
    end
    check("relock_after_17", 32'(locked_o), 1);
    check("hunt_no_count", word_cnt_o, 112);

    // 4. Gapped stream, then all-zero stream
    do_reset();
    saw = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send_clean();
      saw = saw | err_o;
      if (i == 17) check("gap_lock_17", 32'(locked_o), 1);
      send($urandom, 1'b0);
      saw = saw | err_o;
      if (i == 16) check("gap_not_locked_16", 32'(locked_o), 0);
    end
    check("gap_still_locked", 32'(locked_o), 1);
    check("gap_no_err", 32'(saw), 0);
    check("gap_bit_cnt", bit_err_cnt_o, 0);
    check("gap_word_cnt", word_cnt_o, 0);
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      send(32'h0, 1'b1);
      saw = saw | locked_o;
    end
    check("zero_never_locks", 32'(saw), 0);

    // 5. Saturation and clear on the 4-bit counter instance
    do_reset();
    for (int i = 0; i < 17; i++) send_clean();
    check("sat_locked", 32'(s_locked_o), 1);
    for (int i = 1; i <= 8; i++) begin
      send_bad(32'h7);
      if (i == 1) check("sat_bit_3", 32'(s_bit_err_cnt_o), 3);
      if (i == 5) check("sat_bit_15", 32'(s_bit_err_cnt_o), 15);
      if (i == 6) check("sat_bit_clamp", 32'(s_bit_err_cnt_o), 15);
    end
    check("sat_bit_final", 32'(s_bit_err_cnt_o), 15);
    check("sat_word_8", 32'(s_word_cnt_o), 8);
    check("sat_still_locked", 32'(s_locked_o), 1);
    clr_i = 1'b1;
    send_clean();
    check("clr_bit", 32'(s_bit_err_cnt_o), 0);
    check("clr_word", 32'(s_word_cnt_o), 0);
    check("clr_keeps_lock", 32'(s_locked_o), 1);
    send_clean();
    check("after_clr_word", 32'(s_word_cnt_o), 1);
    for (int i = 0; i < 20; i++) send_clean();
    check("word_sat_15", 32'(s_word_cnt_o), 15);
    check("word_sat_bits", 32'(s_bit_err_cnt_o), 0);

    // 6. Reset mid-lock with valid and clear asserted
    do_reset();
    for (int i = 0; i < 17; i++) send_clean();
    send_bad(32'h1);
    check("pre_rst_bit", bit_err_cnt_o, 1);
    check("pre_rst_word", word_cnt_o, 1);
    rst     = 1'b1;
    valid_i = 1'b1;
    clr_i   = 1'b1;
    data_i  = gen;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    check("rst_locked", 32'(locked_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_bit", bit_err_cnt_o, 0);
    check("rst_word", word_cnt_o, 0);
    for (int i = 1; i <= 17; i++) begin
      send_clean();
      if (i == 16) check("rst_relock_not_16", 32'(locked_o), 0);
    end
    check("rst_relock_17", 32'(locked_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
